// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: buffered UART on the CSR bus with RX/TX byte FIFOs.
// Define CSR_UART_FIFO_LOOPBACK_EN to feed the receiver from tx internally.
module csr_uart_fifo #(
   parameter logic [11:0] BASE_ADDR  = 12'hBC0,
   parameter int          CLOCK_RATE = 12_000_000,
   parameter int          BAUD_RATE  = 115200,
   parameter int          DEPTH      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [2:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   input  logic        rx,
   output logic        tx
);
   localparam int DIV_RAW = CLOCK_RATE / BAUD_RATE;
   localparam int DIV = (DIV_RAW < 8) ? 8 : DIV_RAW;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;

   logic [7:0]  rx_mem [DEPTH];
   logic [AW:0] rx_wp, rx_rp;
   logic [7:0]  tx_mem [DEPTH];
   logic [AW:0] tx_wp, tx_rp;
   logic        rx_empty, rx_full;
   logic        tx_empty, tx_full;
   logic        rx_ovr;

   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                     (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign tx_empty = tx_wp == tx_rp;
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                     (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

   logic        hit, op_wr;
   logic [31:0] r_val, n_val;
   logic        rx_pop, tx_push, ovr_clr;

   always_comb begin
      hit   = read && (addr == BASE_ADDR);
      r_val = {21'd0, rx_ovr, tx_full, !rx_empty,
               rx_empty ? 8'd0 : rx_mem[rx_rp[AW-1:0]]};
      n_val = wdata;
      op_wr = 1'b0;
      unique case (1'b1)
         modify == 3'b001: begin
            n_val = wdata;
            op_wr = hit;
         end
         modify == 3'b010: begin
            n_val = r_val | wdata;
            op_wr = hit;
         end
         modify == 3'b100: begin
            n_val = r_val & ~wdata;
            op_wr = hit;
         end
         default: ;
      endcase
      rx_pop  = hit && (modify == 3'b000) && !rx_empty;
      tx_push = op_wr && !n_val[31] && !tx_full;
      ovr_clr = op_wr && n_val[31];
   end

   logic unused_nval;
   assign unused_nval = ^n_val[30:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         rdata <= '0;
      end else begin
         valid <= hit;
         rdata <= hit ? r_val : '0;
      end
   end

   // Transmitter
   state_t        tx_st;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_sh;
   logic          tx_pop;

   assign tx_pop = (tx_st == S_IDLE) && !tx_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st  <= S_IDLE;
         tx     <= 1'b1;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
      end else begin
         unique case (tx_st)
            S_IDLE: if (!tx_empty) begin
               tx_st  <= S_START;
               tx     <= 1'b0;
               tx_cnt <= '0;
               tx_sh  <= tx_mem[tx_rp[AW-1:0]];
            end
            S_START: if (tx_cnt == DIV_LAST) begin
               tx_st  <= S_DATA;
               tx     <= tx_sh[0];
               tx_cnt <= '0;
               tx_bit <= '0;
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
            S_DATA: if (tx_cnt == DIV_LAST) begin
               tx_cnt <= '0;
               if (tx_bit == 3'd7) begin
                  tx_st <= S_STOP;
                  tx    <= 1'b1;
               end else begin
                  tx_bit <= tx_bit + 1'b1;
                  tx     <= tx_sh[1];
                  tx_sh  <= {1'b0, tx_sh[7:1]};
               end
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
            S_STOP: if (tx_cnt == DIV_LAST) begin
               tx_st  <= S_IDLE;
               tx_cnt <= '0;
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
         endcase
      end
   end

   logic rx_in;
`ifdef CSR_UART_FIFO_LOOPBACK_EN
   logic unused_rx;
   assign unused_rx = rx;
   assign rx_in = tx;
`else
   logic rx_s1, rx_s2;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end
   assign rx_in = rx_s2;
`endif

   // Receiver: start bit checked mid-bit, then one sample per DIV
   state_t        rx_st;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic          rx_prev;
   logic          rx_push, rx_wr_ok;

   assign rx_push  = (rx_st == S_STOP) && (rx_cnt == DIV_LAST) &&
                     rx_in;
   assign rx_wr_ok = rx_push && (!rx_full || rx_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_st   <= S_IDLE;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
         rx_prev <= 1'b1;
      end else begin
         rx_prev <= rx_in;
         unique case (rx_st)
            S_IDLE: if (rx_prev && !rx_in) begin
               rx_st  <= S_START;
               rx_cnt <= '0;
            end
            S_START: if (rx_cnt == HALF_LAST) begin
               rx_st  <= rx_in ? S_IDLE : S_DATA;
               rx_cnt <= '0;
               rx_bit <= '0;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
            S_DATA: if (rx_cnt == DIV_LAST) begin
               rx_cnt <= '0;
               rx_sh  <= {rx_in, rx_sh[7:1]};
               if (rx_bit == 3'd7)
                  rx_st <= S_STOP;
               else
                  rx_bit <= rx_bit + 1'b1;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
            S_STOP: if (rx_cnt == DIV_LAST) begin
               rx_st  <= S_IDLE;
               rx_cnt <= '0;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_wr_ok)
         rx_mem[rx_wp[AW-1:0]] <= rx_sh;
      if (tx_push)
         tx_mem[tx_wp[AW-1:0]] <= n_val[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_ovr <= 1'b0;
      end else begin
         if (rx_wr_ok)
            rx_wp <= rx_wp + 1'b1;
         if (rx_pop)
            rx_rp <= rx_rp + 1'b1;
         if (tx_push)
            tx_wp <= tx_wp + 1'b1;
         if (tx_pop)
            tx_rp <= tx_rp + 1'b1;
         if (rx_push && rx_full && !rx_pop)
            rx_ovr <= 1'b1;
         else if (ovr_clr)
            rx_ovr <= 1'b0;
      end
   end
endmodule
